pipeline_hazard_ctrl: RTL
=========================

// Module: pipeline_hazard_ctrl
// PURPOSE
//  Unified hazard, stall and forwarding controller for the 5-stage MIPS core.
//  Sits beside the ID/EX/MEM/WB pipeline registers and drives PC/IF-ID enables, ID/EX bubble, global freeze and all forward muxes.
//  Adds data-cache stall freeze, a variable-latency MUL/DIV scoreboard FSM and 2-cycle load->branch stall.
// PARAMETERS
//  REG_AW  5   register-address width (2**REG_AW architectural registers)
//  OP_W    6   opcode width
//  CNT_W   32  perf counter width (HAZARD_PERF_EN only)
// PORTS
//  clk            in  1       core clock
//  rst_n          in  1       reset, synchronous, active-low
//  id_opcode      in  OP_W    opcode in ID
//  id_rs, id_rt   in  REG_AW  source regs in ID
//  id_use_rs/rt   in  1       ID instr actually reads rs / rt
//  id_is_md       in  1       ID instr is MUL/DIV
//  id_dst         in  REG_AW  ID destination reg (0 if none)
//  ex_rs, ex_rt   in  REG_AW  source regs in EX
//  ex_dst         in  REG_AW  EX destination (post RegDst mux)
//  ex_reg_write   in  1       EX writes regfile
//  ex_mem_read    in  1       EX is load
//  md_start       in  1       EX issues MUL/DIV this cycle
//  md_done        in  1       MUL/DIV unit result valid (1-cycle pulse)
//  mem_dst, mem_rt in REG_AW  MEM destination / store-data reg
//  mem_reg_write, mem_mem_read, mem_mem_write  in 1  MEM controls
//  wb_dst         in  REG_AW  WB destination
//  wb_reg_write   in  1       WB writes regfile
//  dmem_stall     in  1       D-cache miss in progress
//  pc_write, if_id_write  out 1  PC / IF-ID enable
//  id_ex_bubble   out 1       zero ID/EX controls
//  pipe_freeze    out 1       hold ID/EX, EX/MEM, MEM/WB
//  fwd_a, fwd_b   out 2       EX operand select: 00 RF, 01 WB, 10 MEM
//  fwd_a_id, fwd_b_id out 1   branch-compare operand from MEM
//  fwd_wd_mem     out 1       store data from WB
//  perf_clr       in  1       clear perf counters
//  perf_stall_cnt, perf_bubble_cnt out CNT_W  perf counters
// BEHAVIOUR
//  Reset (rst_n=0 at posedge): FSM->MD_IDLE, md_dst_q=0, counters=0; outputs settle to pc_write=if_id_write=1, others 0. Reset mid-MD abandons op.
//  Stall priority (comb.): dmem_stall > MD hazard > load-use > branch hazard.
//  dmem_stall=1: pipe_freeze=1, pc_write=if_id_write=0, bubble=0; md_start ignored.
//  MD FSM (sub-module): MD_IDLE --md_start&!dmem_stall--> MD_BUSY (latch md_dst_q=ex_dst);
//   MD_BUSY --md_done--> MD_IDLE. In MD_BUSY (incl. md_done cycle), stall ID if id_is_md,
//   or used rs/rt==md_dst_q!=0, or id_dst==md_dst_q!=0 (WAW). Released next cycle.
//  Load-use: ex_mem_read & ex_dst!=0 & matches used rs/rt -> 1 bubble.
//  Branch (opcode 0x04/0x05): ex_reg_write & ex_dst match -> bubble; mem_mem_read & mem_dst match -> bubble. load->beq = 2 bubbles.
//  Any stall except freeze: pc_write=if_id_write=0, id_ex_bubble=1.
//  fwd_a/b: 10 if mem_reg_write & !mem_mem_read & mem_dst==ex_rs/rt!=0; else 01 if wb_reg_write & wb_dst match !=0; else 00. MEM wins over WB.
//  fwd_a/b_id: branch in ID & mem_reg_write & !mem_mem_read & mem_dst==id_rs/rt!=0.
//  fwd_wd_mem: wb_reg_write & mem_mem_write & wb_dst==mem_rt!=0.
//  Register 0 never hazards or forwards.
// CONFIGURATION
//  HAZARD_PERF_EN defined: perf_stall_cnt += 1 per cycle pc_write=0; perf_bubble_cnt += 1 per bubble; saturate at all-ones; perf_clr sync-clears (wins over increment).
//  Undefined: no counter flops, both ports tied 0, perf_clr ignored.
// STRUCTURE
//  hazard_pkg: OP_BEQ/OP_BNE, FWD_RF/FWD_WB/FWD_MEM, md_state_t {MD_IDLE, MD_BUSY}.
//  Sub-module hazard_md_scoreboard: MD FSM + md_dst_q, outputs md_busy, md_dst_q.
// TESTING
//  lw $2 (EX), add uses $2 (ID) -> 1 cycle pc_write=0, id_ex_bubble=1; next cycle fwd_a=01.
//  lw $3 then beq $3,$0 -> 2 consecutive bubbles, then fwd_a_id=0 (RF path).
//  add $4 in MEM, add $4 in WB, sub reads $4 in EX -> fwd_a=10.
//  mult->$5, md_done after 6 cycles, add reads $5 -> stall 6 cycles, released cycle after md_done.
//  dmem_stall=1 for 3 cycles during MD_IDLE with md_start=1 -> pipe_freeze=1 x3, FSM stays MD_IDLE.
//  rst_n=0 during MD_BUSY -> next cycle FSM MD_IDLE, pc_write=1, counters 0.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared constants and types for the pipeline hazard controller.
// Holds branch opcodes, forward-mux select codes and the MUL/DIV state type.
package hazard_pkg;

  localparam logic [5:0] OP_BEQ = 6'h04;
  localparam logic [5:0] OP_BNE = 6'h05;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  typedef enum logic {
    MD_IDLE = 1'b0,
    MD_BUSY = 1'b1
  } md_state_t;

endpackage

// File: rtl/hazard_md_scoreboard.sv
// Tracks one in-flight MUL/DIV op and its destination register.
// Busy from the cycle after a start up to and including the md_done cycle.
module hazard_md_scoreboard #(
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              md_start,
  input  logic              md_done,
  input  logic [REG_AW-1:0] ex_dst,
  output logic              md_busy,
  output logic [REG_AW-1:0] md_dst_q
);
  import hazard_pkg::*;

  md_state_t state;

  // A start while busy is ignored; the unit accepts one op at a time.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= MD_IDLE;
      md_busy  <= 1'b0;
      md_dst_q <= '0;
    end else begin
      case (state)
        MD_IDLE: begin
          if (md_start) begin
            state    <= MD_BUSY;
            md_busy  <= 1'b1;
            md_dst_q <= ex_dst;
          end
        end
        MD_BUSY: begin
          if (md_done) begin
            state   <= MD_IDLE;
            md_busy <= 1'b0;
          end
        end
        default: begin
          state   <= MD_IDLE;
          md_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard, stall and forwarding control for the 5-stage core; all controls are combinational.
// Optional perf counters enabled by HAZARD_PERF_EN; dmem_stall freezes the pipe and overrides all stalls.
module pipeline_hazard_ctrl #(
  parameter int REG_AW = 5,
  parameter int OP_W   = 6,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [OP_W-1:0]   id_opcode,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_use_rs,
  input  logic              id_use_rt,
  input  logic              id_is_md,
  input  logic [REG_AW-1:0] id_dst,
  input  logic [REG_AW-1:0] ex_rs,
  input  logic [REG_AW-1:0] ex_rt,
  input  logic [REG_AW-1:0] ex_dst,
  input  logic              ex_reg_write,
  input  logic              ex_mem_read,
  input  logic              md_start,
  input  logic              md_done,
  input  logic [REG_AW-1:0] mem_dst,
  input  logic [REG_AW-1:0] mem_rt,
  input  logic              mem_reg_write,
  input  logic              mem_mem_read,
  input  logic              mem_mem_write,
  input  logic [REG_AW-1:0] wb_dst,
  input  logic              wb_reg_write,
  input  logic              dmem_stall,
  output logic              pc_write,
  output logic              if_id_write,
  output logic              id_ex_bubble,
  output logic              pipe_freeze,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b,
  output logic              fwd_a_id,
  output logic              fwd_b_id,
  output logic              fwd_wd_mem,
  input  logic              perf_clr,
  output logic [CNT_W-1:0]  perf_stall_cnt,
  output logic [CNT_W-1:0]  perf_bubble_cnt
);
  import hazard_pkg::*;

  logic              md_busy;
  logic [REG_AW-1:0] md_dst_q;

  // A frozen pipe must not launch a MUL/DIV, so the start is masked here.
  hazard_md_scoreboard #(.REG_AW(REG_AW)) u_md_sb (
    .clk      (clk),
    .rst_n    (rst_n),
    .md_start (md_start & ~dmem_stall),
    .md_done  (md_done),
    .ex_dst   (ex_dst),
    .md_busy  (md_busy),
    .md_dst_q (md_dst_q)
  );

  function automatic logic reads(input logic use_r, input logic [REG_AW-1:0] r,
                                 input logic [REG_AW-1:0] d);
    return use_r && (d != '0) && (r == d);
  endfunction

  logic id_branch, id_reads_md, md_haz, load_use, branch_haz, any_stall;
  logic mem_fwd_ok;

  assign id_branch = (id_opcode == OP_W'(OP_BEQ)) || (id_opcode == OP_W'(OP_BNE));

  assign id_reads_md = reads(id_use_rs, id_rs, md_dst_q) || reads(id_use_rt, id_rt, md_dst_q)
                     || reads(1'b1, id_dst, md_dst_q);
  assign md_haz      = md_busy && (id_is_md || id_reads_md);

  assign load_use    = ex_mem_read && (reads(id_use_rs, id_rs, ex_dst) || reads(id_use_rt, id_rt, ex_dst));

  // Branches resolve in ID, so an ALU result in EX or a load in MEM is not yet usable.
  assign branch_haz  = id_branch &&
                       ((ex_reg_write && (reads(id_use_rs, id_rs, ex_dst) || reads(id_use_rt, id_rt, ex_dst))) ||
                        (mem_mem_read && (reads(id_use_rs, id_rs, mem_dst) || reads(id_use_rt, id_rt, mem_dst))));

  assign any_stall    = md_haz || load_use || branch_haz;
  assign pipe_freeze  = dmem_stall;
  assign pc_write     = !dmem_stall && !any_stall;
  assign if_id_write  = pc_write;
  assign id_ex_bubble = !dmem_stall && any_stall;

  assign mem_fwd_ok = mem_reg_write && !mem_mem_read;

  always_comb begin
    fwd_a = FWD_RF;
    if (mem_fwd_ok && reads(1'b1, ex_rs, mem_dst))          fwd_a = FWD_MEM;
    else if (wb_reg_write && reads(1'b1, ex_rs, wb_dst))    fwd_a = FWD_WB;
    fwd_b = FWD_RF;
    if (mem_fwd_ok && reads(1'b1, ex_rt, mem_dst))          fwd_b = FWD_MEM;
    else if (wb_reg_write && reads(1'b1, ex_rt, wb_dst))    fwd_b = FWD_WB;
  end

  assign fwd_a_id   = id_branch && mem_fwd_ok && reads(1'b1, id_rs, mem_dst);
  assign fwd_b_id   = id_branch && mem_fwd_ok && reads(1'b1, id_rt, mem_dst);
  assign fwd_wd_mem = wb_reg_write && mem_mem_write && reads(1'b1, mem_rt, wb_dst);

`ifdef HAZARD_PERF_EN
  logic [CNT_W-1:0] stall_cnt_q, bubble_cnt_q;

  always_ff @(posedge clk) begin
    if (!rst_n || perf_clr) begin
      stall_cnt_q  <= '0;
      bubble_cnt_q <= '0;
    end else begin
      if (!pc_write && (stall_cnt_q != '1))      stall_cnt_q  <= stall_cnt_q + 1'b1;
      if (id_ex_bubble && (bubble_cnt_q != '1))  bubble_cnt_q <= bubble_cnt_q + 1'b1;
    end
  end

  assign perf_stall_cnt  = stall_cnt_q;
  assign perf_bubble_cnt = bubble_cnt_q;
`else
  logic unused_perf_clr;
  assign unused_perf_clr = perf_clr;
  assign perf_stall_cnt  = '0;
  assign perf_bubble_cnt = '0;
`endif

endmodule
